// File: rtl/stage_writeback_pkg.sv
// Shared constants for the writeback stage: opcode layout and FSM state encoding.
package stage_writeback_pkg;

  // One-hot opcode vector; bits not named here carry pointer/loop ops.
  localparam int unsigned OPCODE_MSB = 7;
  localparam int unsigned OP_INC     = 0;
  localparam int unsigned OP_DEC     = 1;
  localparam int unsigned OP_OUT     = 4;
  localparam int unsigned OP_IN      = 5;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_MEM_WR = 2'd1,
    WB_PORT   = 2'd2,
    WB_ACK    = 2'd3
  } wb_state_e;

endpackage

// File: rtl/stage_writeback_if.sv
// Writeback stage bus: upstream drdy/ack handshake, memory write port, output port.
interface stage_writeback_if #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 16
) ();
  import stage_writeback_pkg::*;

  logic [OPCODE_MSB:0] operation_in;
  logic [D_WIDTH-1:0]  a_in;
  logic [A_WIDTH-1:0]  addr_in;
  logic                drdy_in;
  logic                ack;

  logic                mem_we;
  logic [A_WIDTH-1:0]  mem_addr;
  logic [D_WIDTH-1:0]  mem_wdata;
  logic                mem_ack;

  logic [D_WIDTH-1:0]  out_data;
  logic                out_valid;
  logic                out_ready;

  // Environment side: upstream stage, data memory and output sink.
  modport master (
    output operation_in, a_in, addr_in, drdy_in, mem_ack, out_ready,
    input  ack, mem_we, mem_addr, mem_wdata, out_data, out_valid
  );

  // Writeback stage side.
  modport slave (
    input  operation_in, a_in, addr_in, drdy_in, mem_ack, out_ready,
    output ack, mem_we, mem_addr, mem_wdata, out_data, out_valid
  );

endinterface

// File: rtl/stage_writeback.sv
// Final pipeline stage: retires each transaction as a memory write (INC/DEC/IN),
// an output-port byte (OUT) or a plain ack, stalling while memory/port are busy.
// Optional macro WRITEBACK_FWD_EN adds fwd_valid/fwd_addr/fwd_data, a copy of the
// last completed memory write for the read stage to bypass.
module stage_writeback
  import stage_writeback_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  stage_writeback_if.slave   bus
`ifdef WRITEBACK_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [A_WIDTH-1:0] fwd_addr,
  output logic [D_WIDTH-1:0] fwd_data
`endif
);

  wb_state_e          state_q, state_d;
  logic               ack_q, ack_d;
  logic               mem_we_q, mem_we_d;
  logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic               out_valid_q, out_valid_d;
  logic [D_WIDTH-1:0] out_data_q, out_data_d;

  logic op_mem_c;
  logic op_port_c;
  logic unused_op_bits;

  // Opcode classes; any memory-writing opcode outranks OUT.
  assign op_mem_c       = bus.operation_in[OP_INC] | bus.operation_in[OP_DEC] | bus.operation_in[OP_IN];
  assign op_port_c      = bus.operation_in[OP_OUT];
  assign unused_op_bits = ^bus.operation_in;

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      WB_IDLE: begin
        if (bus.drdy_in) begin
          if (op_mem_c) begin
            state_d     = WB_MEM_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.addr_in;
            mem_wdata_d = bus.a_in;
          end else if (op_port_c) begin
            state_d     = WB_PORT;
            out_valid_d = 1'b1;
            out_data_d  = bus.a_in;
          end else begin
            state_d = WB_ACK;
            ack_d   = 1'b1;
          end
        end
      end
      WB_MEM_WR: begin
        if (bus.mem_ack) begin
          state_d  = WB_ACK;
          mem_we_d = 1'b0;
          ack_d    = 1'b1;
        end
      end
      WB_PORT: begin
        if (bus.out_ready) begin
          state_d     = WB_PORT == WB_PORT ? WB_ACK : WB_ACK;
          out_valid_d = 1'b0;
          ack_d       = 1'b1;
        end
      end
      WB_ACK: begin
        state_d = WB_IDLE;
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WB_IDLE;
      ack_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef WRITEBACK_FWD_EN
  // Capture each completed memory write for read-stage bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else if (state_q == WB_MEM_WR && bus.mem_ack) begin
      fwd_valid <= 1'b1;
      fwd_addr  <= mem_addr_q;
      fwd_data  <= mem_wdata_q;
    end
  end
`endif

endmodule
